// File: rtl/fp16_pkg.sv
// Shared types and constants for the fp16 MAC operand feeder.
package fp16_pkg;
  localparam int FP16_W = 16;
  localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;

  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [FP16_W-1:0] a;
    logic [FP16_W-1:0] b;
  } pair_t;
endpackage

// File: rtl/fp16_mac_feeder_if.sv
// Host load/result handshake plus the fp16MAC operand/accumulator link.
interface fp16_mac_feeder_if;
  import fp16_pkg::*;

  logic              wr_en;
  logic [FP16_W-1:0] wr_a;
  logic [FP16_W-1:0] wr_b;
  logic              wr_full;
  logic              start;
  logic              busy;
  logic [FP16_W-1:0] mac_a;
  logic [FP16_W-1:0] mac_b;
  logic              mac_clr_n;
  logic [FP16_W-1:0] mac_acc;
  logic [FP16_W-1:0] result;
  logic              result_valid;
  logic              result_ack;

  // master = host side plus the MAC's accumulator output; slave = the feeder
  modport master (
    output wr_en, wr_a, wr_b, start, result_ack, mac_acc,
    input  wr_full, busy, mac_a, mac_b, mac_clr_n, result, result_valid
  );

  modport slave (
    input  wr_en, wr_a, wr_b, start, result_ack, mac_acc,
    output wr_full, busy, mac_a, mac_b, mac_clr_n, result, result_valid
  );
endinterface

// File: rtl/fp16_mac_feeder_pair_buf.sv
// Operand-pair register file: synchronous write, asynchronous read.
module pair_buf
  import fp16_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  pair_t             wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output pair_t             rd_data
);
  pair_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/fp16_mac_feeder.sv
// Buffers fp16 operand pairs, streams them into an external fp16MAC after
// clearing its accumulator, and captures the dot product for the host.
module fp16_mac_feeder
  import fp16_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int MAC_LAT = 1
) (
  input logic               CLK,
  input logic               RESETn,
  fp16_mac_feeder_if.slave  bus
);
  localparam int CNT_W   = ADDR_W + 1;
  localparam int DRAIN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    count_reg, count_next;
  logic [ADDR_W-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [DRAIN_W-1:0]  drain_reg, drain_next;
  logic [FP16_W-1:0]   result_reg, result_next;
  logic                result_valid_reg, result_valid_next;
  logic                mac_clr_n_reg;

  logic  is_full;
  logic  wr_accept;
  logic  stream_last;
  logic  drain_last;
  pair_t wr_pair;
  pair_t rd_pair;

  assign is_full     = (count_reg == CNT_W'(DEPTH));
  assign wr_accept   = (state_reg == IDLE) && bus.wr_en && !is_full;
  assign stream_last = ({1'b0, rd_ptr_reg} == count_reg - CNT_W'(1));
  assign drain_last  = (drain_reg == DRAIN_W'(MAC_LAT - 1));
  assign wr_pair     = {bus.wr_a, bus.wr_b};

  pair_buf #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_pair_buf (
    .clk     (CLK),
    .wr_en   (wr_accept),
    .wr_addr (count_reg[ADDR_W-1:0]),
    .wr_data (wr_pair),
    .rd_addr (rd_ptr_reg),
    .rd_data (rd_pair)
  );

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = CLEAR;
      CLEAR:   state_next = (count_reg != '0) ? STREAM : DONE;
      STREAM:  if (stream_last) state_next = DRAIN;
      DRAIN:   if (drain_last) state_next = DONE;
      DONE:    if (bus.result_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    count_next        = count_reg;
    rd_ptr_next       = rd_ptr_reg;
    drain_next        = drain_reg;
    result_next       = result_reg;
    result_valid_next = result_valid_reg;
    case (state_reg)
      IDLE: begin
        if (wr_accept) count_next = count_reg + CNT_W'(1);
      end
      CLEAR: begin
        rd_ptr_next = '0;
        drain_next  = '0;
        // Nothing to stream: the dot product of an empty set is +0.
        if (count_reg == '0) begin
          result_next       = FP16_ZERO;
          result_valid_next = 1'b1;
        end
      end
      STREAM: begin
        rd_ptr_next = rd_ptr_reg + ADDR_W'(1);
      end
      DRAIN: begin
        drain_next = drain_reg + DRAIN_W'(1);
        if (drain_last) begin
          result_next       = bus.mac_acc;
          result_valid_next = 1'b1;
        end
      end
      DONE: begin
        if (bus.result_ack) begin
          result_valid_next = 1'b0;
          count_next        = '0;
        end
      end
      default: ;
    endcase
  end

  // mac_clr_n feeds the MAC's asynchronous reset, so it comes straight from a flop.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      count_reg        <= '0;
      rd_ptr_reg       <= '0;
      drain_reg        <= '0;
      result_reg       <= FP16_ZERO;
      result_valid_reg <= 1'b0;
      mac_clr_n_reg    <= 1'b1;
    end else begin
      count_reg        <= count_next;
      rd_ptr_reg       <= rd_ptr_next;
      drain_reg        <= drain_next;
      result_reg       <= result_next;
      result_valid_reg <= result_valid_next;
      mac_clr_n_reg    <= (state_next != CLEAR);
    end
  end

  // Outside STREAM the MAC sees +0 * +0, which leaves the accumulator unchanged.
  assign bus.mac_a        = (state_reg == STREAM) ? rd_pair.a : FP16_ZERO;
  assign bus.mac_b        = (state_reg == STREAM) ? rd_pair.b : FP16_ZERO;
  assign bus.mac_clr_n    = mac_clr_n_reg;
  assign bus.busy         = (state_reg != IDLE);
  assign bus.wr_full      = is_full;
  assign bus.result       = result_reg;
  assign bus.result_valid = result_valid_reg;
endmodule

// File: tb/tb_fp16_mac_feeder.sv
// Bench for fp16_mac_feeder: behavioural fp16MAC, host-level model, per-cycle compare.
module tb_fp16_mac_feeder;
  import fp16_pkg::*;

  localparam int DEPTH   = 16;
  localparam int ADDR_W  = 4;
  localparam int MAC_LAT = 1;

  logic CLK    = 1'b0;
  logic RESETn = 1'b0;

  fp16_mac_feeder_if bus();

  fp16_mac_feeder #(
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .MAC_LAT (MAC_LAT)
  ) dut (
    .CLK    (CLK),
    .RESETn (RESETn),
    .bus    (bus)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // fp16 <-> real; double holds every fp16 product and sum used here exactly
  function automatic real h2r(input logic [15:0] h);
    int  e;
    real m;
    e = int'(h[14:10]);
    if (e == 0) m = real'(int'(h[9:0])) * $pow(2.0, -24);
    else        m = real'(1024 + int'(h[9:0])) * $pow(2.0, real'(e - 25));
    return h[15] ? -m : m;
  endfunction

  function automatic logic [15:0] r2h(input real r);
    real  a, q, fl;
    int   e, qi;
    logic s;
    if (r == 0.0) return 16'h0000;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 0;
    while (a >= $pow(2.0, real'(e + 1))) e++;
    while (a < $pow(2.0, real'(e))) e--;
    if (e < -14) q = a * $pow(2.0, 24.0);
    else         q = a * $pow(2.0, real'(10 - e));
    fl = $floor(q);
    qi = $rtoi(fl);
    if ((q - fl > 0.5) || ((q - fl == 0.5) && qi[0])) qi++;
    if (e < -14) return {s, 15'(qi)};
    if (qi == 2048) begin
      qi = 1024;
      e++;
    end
    if (e > 15) return {s, 5'h1f, 10'h000};
    return {s, 5'(e + 15), 10'(qi - 1024)};
  endfunction

  function automatic logic [15:0] fmac(input logic [15:0] acc, input logic [15:0] a,
                                       input logic [15:0] b);
    return r2h(h2r(acc) + h2r(r2h(h2r(a) * h2r(b))));
  endfunction

  // Behavioural fp16MAC: one-cycle latency, asynchronous active-low clear.
  logic [15:0] mac_acc_q = 16'h0000;
  assign bus.mac_acc = mac_acc_q;
  always @(posedge CLK or negedge bus.mac_clr_n) begin
    if (!bus.mac_clr_n) mac_acc_q <= 16'h0000;
    else                mac_acc_q <= fmac(mac_acc_q, bus.mac_a, bus.mac_b);
  end

  // Host-level model: queue of accepted pairs and a cycle offset t since start.
  int          m_count = 0;
  bit          m_run   = 0;
  int          m_t     = 0;
  int          m_n     = 0;
  logic [15:0] m_qa[$];
  logic [15:0] m_qb[$];
  logic [15:0] m_ra[DEPTH];
  logic [15:0] m_rb[DEPTH];
  logic [15:0] m_exp  = 16'h0000;
  logic [15:0] m_last = 16'h0000;

  function automatic int done_t(input int n);
    return (n == 0) ? 1 : n + MAC_LAT + 1;
  endfunction

  initial forever begin
    @(posedge CLK or negedge RESETn);
    if (!RESETn) begin
      m_count = 0; m_run = 0; m_t = 0; m_n = 0; m_last = 16'h0000;
      m_qa.delete(); m_qb.delete();
    end else if (!m_run) begin
      if (bus.wr_en && m_count < DEPTH) begin
        m_qa.push_back(bus.wr_a);
        m_qb.push_back(bus.wr_b);
        m_count++;
      end
      if (bus.start) begin
        m_run = 1; m_t = 0; m_n = m_count; m_exp = 16'h0000;
        for (int i = 0; i < m_count; i++) begin
          m_ra[i] = m_qa[i];
          m_rb[i] = m_qb[i];
          m_exp   = fmac(m_exp, m_qa[i], m_qb[i]);
        end
      end
    end else begin
      if (m_t >= done_t(m_n) && bus.result_ack) begin
        m_run = 0; m_count = 0;
        m_qa.delete(); m_qb.delete();
      end else begin
        m_t++;
        if (m_t == done_t(m_n)) m_last = m_exp;
      end
    end
  end

  initial forever begin
    @(negedge CLK);
    check("busy", 32'(bus.busy), 32'(m_run));
    check("mac_clr_n", 32'(bus.mac_clr_n), 32'(!(m_run && m_t == 0)));
    check("mac_a", 32'(bus.mac_a), (m_run && m_t >= 1 && m_t <= m_n) ? 32'(m_ra[m_t-1]) : 32'h0);
    check("mac_b", 32'(bus.mac_b), (m_run && m_t >= 1 && m_t <= m_n) ? 32'(m_rb[m_t-1]) : 32'h0);
    check("result_valid", 32'(bus.result_valid), 32'(m_run && m_t >= done_t(m_n)));
    check("result", 32'(bus.result), 32'(m_last));
    check("wr_full", 32'(bus.wr_full), 32'(m_count == DEPTH));
  end

  logic [15:0] tr_a   [64];
  logic [15:0] tr_b   [64];
  logic        tr_clr [64];
  bit          noise = 0;

  task automatic write_pair(input logic [15:0] a, input logic [15:0] b);
    bus.wr_en = 1'b1; bus.wr_a = a; bus.wr_b = b;
    @(negedge CLK);
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
      bus.start = 1'b0;
      bus.wr_en = 1'b0;
      if (noise) begin
        bus.wr_en = 1'($urandom_range(0, 1));
        bus.wr_a  = 16'($urandom);
        bus.wr_b  = 16'($urandom);
        bus.start = ($urandom_range(0, 3) == 0);
      end
      if (lat < 64) begin
        tr_a[lat] = bus.mac_a; tr_b[lat] = bus.mac_b; tr_clr[lat] = bus.mac_clr_n;
      end
    end while (!bus.result_valid && lat < 200);
    bus.wr_en = 1'b0;
    bus.start = 1'b0;
    if (!bus.result_valid) check("valid_timeout", 32'(lat), 32'(0));
  endtask

  task automatic ack_result(input int delay);
    repeat (delay) @(negedge CLK);
    bus.result_ack = 1'b1;
    @(negedge CLK);
    bus.result_ack = 1'b0;
  endtask

  function automatic logic [15:0] rand_h();
    logic [15:0] h;
    if ($urandom_range(0, 7) == 0) return 16'h0000;
    h = {1'($urandom_range(0, 1)), 5'($urandom_range(11, 18)), 10'($urandom_range(0, 1023))};
    return h;
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int lat;
    int nw;
    bit started;
    bus.wr_en = 1'b0; bus.wr_a = 16'h0; bus.wr_b = 16'h0;
    bus.start = 1'b0; bus.result_ack = 1'b0;
    RESETn = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_mac_clr_n", 32'(bus.mac_clr_n), 32'h1);
    check("rst_mac_a", 32'(bus.mac_a), 32'h0);
    check("rst_mac_b", 32'(bus.mac_b), 32'h0);
    check("rst_valid", 32'(bus.result_valid), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_wr_full", 32'(bus.wr_full), 32'h0);
    RESETn = 1'b1;
    @(negedge CLK);

    // 1.0 * 2.0
    write_pair(16'h3C00, 16'h4000);
    bus.start = 1'b1;
    wait_result(lat);
    check("single_lat", 32'(lat), 32'd4);
    check("single_res", 32'(bus.result), 32'h4000);
    ack_result(0);

    // 3 x (-13.578125 * -33.65625) -> 3 x 457.0 = 1371.0
    repeat (3) write_pair(16'hCACA, 16'hD035);
    bus.start = 1'b1;
    wait_result(lat);
    check("ref_lat", 32'(lat), 32'd6);
    check("ref_res", 32'(bus.result), 32'h655B);
    check("ref_clr_low", 32'(tr_clr[1]), 32'h0);
    check("ref_clr_high", 32'(tr_clr[2]), 32'h1);
    check("ref_pre_a", 32'(tr_a[1]), 32'h0);
    for (int k = 2; k <= 4; k++) begin
      check("ref_stream_a", 32'(tr_a[k]), 32'hCACA);
      check("ref_stream_b", 32'(tr_b[k]), 32'hD035);
    end
    check("ref_post_a", 32'(tr_a[5]), 32'h0);
    ack_result(1);

    // 17 writes of 1.0*1.0: 16 accepted
    for (int i = 0; i < 17; i++) begin
      write_pair(16'h3C00, 16'h3C00);
      if (i == 14) check("full_at15", 32'(bus.wr_full), 32'h0);
      if (i == 15) check("full_at16", 32'(bus.wr_full), 32'h1);
    end
    bus.start = 1'b1;
    wait_result(lat);
    check("full_lat", 32'(lat), 32'd19);
    check("full_res", 32'(bus.result), 32'h4C00);
    ack_result(0);

    bus.start = 1'b1;
    wait_result(lat);
    check("empty_lat", 32'(lat), 32'd2);
    check("empty_res", 32'(bus.result), 32'h0000);
    check("empty_no_a", 32'(tr_a[1]), 32'h0);
    ack_result(0);

    repeat (5) write_pair(16'h3C00, 16'h4000);
    bus.start = 1'b1;
    @(negedge CLK);
    bus.start = 1'b0;
    repeat (2) @(negedge CLK);
    #2 RESETn = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'h0);
    check("abort_clr_n", 32'(bus.mac_clr_n), 32'h1);
    check("abort_mac_a", 32'(bus.mac_a), 32'h0);
    check("abort_mac_b", 32'(bus.mac_b), 32'h0);
    check("abort_valid", 32'(bus.result_valid), 32'h0);
    check("abort_full", 32'(bus.wr_full), 32'h0);
    @(negedge CLK);
    RESETn = 1'b1;
    @(negedge CLK);
    bus.start = 1'b1;
    wait_result(lat);
    check("abort_lat", 32'(lat), 32'd2);
    check("abort_res", 32'(bus.result), 32'h0000);
    ack_result(0);

    for (int r = 0; r < 40; r++) begin
      nw = $urandom_range(0, 18);
      started = 0;
      for (int i = 0; i < nw; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          bus.result_ack = 1'($urandom_range(0, 1));
          @(negedge CLK);
          bus.result_ack = 1'b0;
        end
        if (i == nw - 1 && $urandom_range(0, 2) == 0) begin
          bus.wr_en = 1'b1; bus.wr_a = rand_h(); bus.wr_b = rand_h();
          bus.start = 1'b1;
          started = 1;
        end else begin
          write_pair(rand_h(), rand_h());
        end
      end
      if (!started) bus.start = 1'b1;
      noise = 1;
      wait_result(lat);
      noise = 0;
      check("rand_lat", 32'(lat), (m_n == 0) ? 32'd2 : 32'(m_n + MAC_LAT + 2));
      ack_result($urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
